// File: rtl/nibbler_datapath_if.sv
// nibbler_datapath_if
//   Bundles the fetch, accumulator and ALU signals of the nibbler datapath.
//   master : the sequencer/controller side (drives enables, program byte, ALU controls)
//   slave  : the datapath side (returns fetched nibbles, accumulator and ALU results)
// Signals:
//   fetch_en  - fetch register load enable
//   prog_byte - program byte from program ROM
//   instr     - registered opcode nibble
//   operand   - registered operand nibble
//   load_a    - accumulator load enable
//   alu_op    - ALU operation select
//   b_in      - ALU B operand
//   acc       - accumulator value (ALU A operand)
//   alu_out   - combinational ALU result
//   carry     - combinational ALU carry
//   zero      - combinational ALU zero flag
interface nibbler_datapath_if;
   logic       fetch_en;
   logic [7:0] prog_byte;
   logic [3:0] instr;
   logic [3:0] operand;
   logic       load_a;
   logic [2:0] alu_op;
   logic [3:0] b_in;
   logic [3:0] acc;
   logic [3:0] alu_out;
   logic       carry;
   logic       zero;

   modport master (
      output fetch_en, prog_byte, load_a, alu_op, b_in,
      input  instr, operand, acc, alu_out, carry, zero
   );

   modport slave (
      input  fetch_en, prog_byte, load_a, alu_op, b_in,
      output instr, operand, acc, alu_out, carry, zero
   );
endinterface

// File: rtl/nibbler_datapath.sv
// nibbler_datapath
//   4-bit datapath: an 8-bit fetch register split into opcode/operand nibbles, a 4-bit
//   accumulator and a purely combinational ALU whose A operand is the accumulator.
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - asynchronous active-high reset of all registers
//   bus   - nibbler_datapath_if.slave (fetch/accumulator controls in, nibbles/ALU results out)
module nibbler_datapath (
   input logic                clk,
   input logic                reset,
   nibbler_datapath_if.slave  bus
);

   localparam logic [2:0] OpPassA = 3'b000;
   localparam logic [2:0] OpSub   = 3'b001;
   localparam logic [2:0] OpPassB = 3'b010;
   localparam logic [2:0] OpAdd   = 3'b011;
   localparam logic [2:0] OpNand  = 3'b100;

   logic [3:0] r_instr;
   logic [3:0] r_operand;
   logic [3:0] r_acc;

   logic [4:0] w_sum;
   logic [4:0] w_diff;
   logic [3:0] w_alu_out;
   logic       w_carry;

   // Fetch register: captures the whole program byte when fetch_en is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr   <= 4'b0000;
         r_operand <= 4'b0000;
      end else if (bus.fetch_en) begin
         r_instr   <= bus.prog_byte[7:4];
         r_operand <= bus.prog_byte[3:0];
      end
   end

   // Accumulator: loads the ALU result computed from the pre-edge accumulator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc <= 4'b0000;
      end else if (bus.load_a) begin
         r_acc <= w_alu_out;
      end
   end

   // Subtract is acc + ~b + 1, so bit 4 is the "no borrow" flag (acc >= b).
   assign w_sum  = {1'b0, r_acc} + {1'b0, bus.b_in};
   assign w_diff = {1'b0, r_acc} + {1'b0, ~bus.b_in} + 5'd1;

   always_comb begin
      w_alu_out = 4'b0000;
      w_carry   = 1'b0;
      case (bus.alu_op)
         OpPassA: w_alu_out = r_acc;
         OpSub: begin
            w_alu_out = w_diff[3:0];
            w_carry   = w_diff[4];
         end
         OpPassB: w_alu_out = bus.b_in;
         OpAdd: begin
            w_alu_out = w_sum[3:0];
            w_carry   = w_sum[4];
         end
         OpNand:  w_alu_out = ~(r_acc & bus.b_in);
         default: begin
            w_alu_out = 4'b0000;
            w_carry   = 1'b0;
         end
      endcase
   end

   assign bus.instr   = r_instr;
   assign bus.operand = r_operand;
   assign bus.acc     = r_acc;
   assign bus.alu_out = w_alu_out;
   assign bus.carry   = w_carry;
   assign bus.zero    = (w_alu_out == 4'b0000);

endmodule

// File: tb/tb_nibbler_datapath.sv
// tb_nibbler_datapath
//   Directed-vector bench for nibbler_datapath with hand-computed expected values.
module tb_nibbler_datapath;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   nibbler_datapath_if bus ();

   nibbler_datapath u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_alu(input string tag, input logic [3:0] out, input logic c,
                            input logic z);
      check_val({tag, ".alu_out"}, {4'h0, bus.alu_out}, {4'h0, out});
      check_val({tag, ".carry"},   {7'h0, bus.carry},   {7'h0, c});
      check_val({tag, ".zero"},    {7'h0, bus.zero},    {7'h0, z});
   endtask

   // Load the accumulator through the pass-B path.
   task automatic set_acc(input logic [3:0] v);
      bus.alu_op = 3'b010;
      bus.b_in   = v;
      bus.load_a = 1'b1;
      @(posedge clk);
      #1;
      bus.load_a = 1'b0;
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      clk           = 1'b0;
      reset         = 1'b1;
      bus.fetch_en  = 1'b0;
      bus.prog_byte = 8'h00;
      bus.load_a    = 1'b0;
      bus.alu_op    = 3'b000;
      bus.b_in      = 4'h0;

      // Reset state, including enables held high during reset.
      #1;
      check_val("rst.instr",   {4'h0, bus.instr},   8'h00);
      check_val("rst.operand", {4'h0, bus.operand}, 8'h00);
      check_val("rst.acc",     {4'h0, bus.acc},     8'h00);
      check_alu("rst.pass_a", 4'h0, 1'b0, 1'b1);
      bus.fetch_en  = 1'b1;
      bus.prog_byte = 8'hFF;
      bus.load_a    = 1'b1;
      bus.alu_op    = 3'b010;
      bus.b_in      = 4'hF;
      @(posedge clk);
      #1;
      check_val("rst_hold.instr", {4'h0, bus.instr}, 8'h00);
      check_val("rst_hold.acc",   {4'h0, bus.acc},   8'h00);
      bus.fetch_en = 1'b0;
      bus.load_a   = 1'b0;
      bus.alu_op   = 3'b000;
      bus.b_in     = 4'h0;
      @(negedge clk);
      reset = 1'b0;

      // Fetch and hold.
      bus.prog_byte = 8'hA5;
      bus.fetch_en  = 1'b1;
      @(posedge clk);
      #1;
      check_val("fetch.instr",   {4'h0, bus.instr},   8'h0A);
      check_val("fetch.operand", {4'h0, bus.operand}, 8'h05);
      bus.prog_byte = 8'h3C;
      bus.fetch_en  = 1'b0;
      @(posedge clk);
      #1;
      check_val("hold.instr",   {4'h0, bus.instr},   8'h0A);
      check_val("hold.operand", {4'h0, bus.operand}, 8'h05);

      // Load through B.
      set_acc(4'h7);
      check_val("ldb.acc", {4'h0, bus.acc}, 8'h07);
      check_alu("ldb.flags", 4'h7, 1'b0, 1'b0);
      bus.alu_op = 3'b000;
      #1;
      check_alu("pass_a", 4'h7, 1'b0, 1'b0);
      // load_a low: acc must hold even though ALU result differs.
      bus.alu_op = 3'b010;
      bus.b_in   = 4'h2;
      @(posedge clk);
      #1;
      check_val("acc_hold", {4'h0, bus.acc}, 8'h07);

      // Asynchronous reset pulse between edges (acc=7, operand=5).
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_val("arst.acc",     {4'h0, bus.acc},     8'h00);
      check_val("arst.instr",   {4'h0, bus.instr},   8'h00);
      check_val("arst.operand", {4'h0, bus.operand}, 8'h00);
      reset = 1'b0;
      #1;
      check_val("arst_rel.acc", {4'h0, bus.acc}, 8'h00);

      // Add with overflow.
      set_acc(4'h9);
      bus.alu_op = 3'b011;
      bus.b_in   = 4'h8;
      #1;
      check_alu("add_9_8", 4'h1, 1'b1, 1'b0);
      set_acc(4'h8);
      bus.alu_op = 3'b011;
      bus.b_in   = 4'h8;
      #1;
      check_alu("add_8_8", 4'h0, 1'b1, 1'b1);
      bus.b_in = 4'h3;
      #1;
      check_alu("add_8_3", 4'hB, 1'b0, 1'b0);
      bus.load_a = 1'b1;
      @(posedge clk);
      #1;
      bus.load_a = 1'b0;
      check_val("acc_add", {4'h0, bus.acc}, 8'h0B);

      // Compare / subtract.
      set_acc(4'h5);
      bus.alu_op = 3'b001;
      bus.b_in   = 4'h5;
      #1;
      check_alu("sub_5_5", 4'h0, 1'b1, 1'b1);
      bus.b_in = 4'h6;
      #1;
      check_alu("sub_5_6", 4'hF, 1'b0, 1'b0);
      bus.b_in = 4'h2;
      #1;
      check_alu("sub_5_2", 4'h3, 1'b1, 1'b0);

      // NAND and invalid ops.
      set_acc(4'hF);
      bus.alu_op = 3'b100;
      bus.b_in   = 4'hF;
      #1;
      check_alu("nand_f_f", 4'h0, 1'b0, 1'b1);
      bus.b_in = 4'h5;
      #1;
      check_alu("nand_f_5", 4'hA, 1'b0, 1'b0);
      bus.alu_op = 3'b101;
      #1;
      check_alu("op101", 4'h0, 1'b0, 1'b1);
      bus.alu_op = 3'b110;
      #1;
      check_alu("op110", 4'h0, 1'b0, 1'b1);
      bus.alu_op = 3'b111;
      #1;
      check_alu("op111", 4'h0, 1'b0, 1'b1);

      // Both enables on one edge; acc uses pre-edge value (3 + 2).
      set_acc(4'h3);
      bus.alu_op    = 3'b011;
      bus.b_in      = 4'h2;
      bus.prog_byte = 8'h96;
      bus.fetch_en  = 1'b1;
      bus.load_a    = 1'b1;
      @(posedge clk);
      #1;
      bus.fetch_en = 1'b0;
      bus.load_a   = 1'b0;
      check_val("both.acc",     {4'h0, bus.acc},     8'h05);
      check_val("both.instr",   {4'h0, bus.instr},   8'h09);
      check_val("both.operand", {4'h0, bus.operand}, 8'h06);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
